// File: rtl/ov7670_pkg.sv
// Shared types and table markers for the OV7670 register-programming sequencer.
package ov7670_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_DELAY,
        S_DONE
    } state_t;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    localparam logic [7:0] DEFAULT_DEVICE_ID = 8'h42;

endpackage

// File: rtl/ov7670_config_seq_if.sv
// Request/acknowledge bundle between the config sequencer and the SCCB sender.
interface ov7670_config_seq_if;

    logic       send;
    logic       taken;
    logic [7:0] id;
    logic [7:0] register;
    logic [7:0] value;

    modport master (
        output send, id, register, value,
        input  taken
    );

    modport slave (
        input  send, id, register, value,
        output taken
    );

endinterface

// File: rtl/ov7670_cfg_rom.sv
// Synchronous 1-cycle ROM holding the OV7670 init table as {reg, val} words.
module ov7670_cfg_rom
    import ov7670_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [15:0]   data
);

    logic [15:0] word;
    int unsigned idx;

    always_comb begin
        idx  = 32'(addr);
        word = CFG_END;
        case (idx)
            0:  word = 16'h1280;
            1:  word = CFG_DELAY;
            2:  word = 16'h1204;
            3:  word = 16'h40D0;
            4:  word = 16'h8C00;
            5:  word = 16'h1180;
            6:  word = 16'h3A04;
            7:  word = 16'h3DC0;
            8:  word = 16'h1713;
            9:  word = 16'h1801;
            10: word = 16'h32B6;
            11: word = 16'h1902;
            12: word = 16'h1A7A;
            13: word = 16'h030A;
            14: word = 16'h0C00;
            15: word = 16'h3E00;
            16: word = 16'h703A;
            17: word = 16'h7135;
            18: word = 16'h7211;
            19: word = 16'h73F0;
            20: word = 16'hA202;
            default: word = CFG_END;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= word;
    end

endmodule

// File: rtl/ov7670_config_seq.sv
// OV7670 register-programming sequencer: walks the ROM table into the SCCB sender.
// Define OV7670_CFG_RESEND_EN to add a resend input that replays the table from S_DONE.
module ov7670_config_seq
    import ov7670_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID   = DEFAULT_DEVICE_ID,
    parameter int         CLK_FREQ_HZ = 25_000_000,
    parameter int         DELAY_MS    = 10,
    parameter int         ROM_AW      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef OV7670_CFG_RESEND_EN
    input  logic                resend,
`endif
    ov7670_config_seq_if.master cfg,
    output logic                busy,
    output logic                done
);

    localparam int DELAY_CYC = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int CW        = $clog2(DELAY_CYC + 1);

    localparam logic [ROM_AW-1:0] ADDR_LAST = '1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DELAY_CYC - 1);

    state_t            state, state_nx;
    logic [ROM_AW-1:0] addr, addr_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [7:0]        reg_q, reg_nx;
    logic [7:0]        val_q, val_nx;
    logic [15:0]       rom_data;
    logic              resend_hit;

`ifdef OV7670_CFG_RESEND_EN
    assign resend_hit = resend;
`else
    assign resend_hit = 1'b0;
`endif

    ov7670_cfg_rom #(
        .AW(ROM_AW)
    ) u_rom (
        .clk  (clk),
        .addr (addr),
        .data (rom_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            addr  <= '0;
            cnt   <= '0;
            reg_q <= '0;
            val_q <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            cnt   <= cnt_nx;
            reg_q <= reg_nx;
            val_q <= val_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        cnt_nx   = cnt;
        reg_nx   = reg_q;
        val_nx   = val_q;
        unique case (state)
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (rom_data == CFG_END): state_nx = S_DONE;
                    (rom_data == CFG_DELAY): begin
                        cnt_nx   = '0;
                        state_nx = S_DELAY;
                    end
                    default: begin
                        reg_nx   = rom_data[15:8];
                        val_nx   = rom_data[7:0];
                        state_nx = S_SEND;
                    end
                endcase
            end
            S_SEND: begin
                if (cfg.taken) begin
                    addr_nx  = addr + 1'b1;
                    state_nx = (addr == ADDR_LAST) ? S_DONE : S_FETCH;
                end
            end
            S_DELAY: begin
                if (cnt == CNT_LAST) begin
                    addr_nx  = addr + 1'b1;
                    state_nx = (addr == ADDR_LAST) ? S_DONE : S_FETCH;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (resend_hit) begin
                    addr_nx  = '0;
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Request decoded from the state register so reset drops it asynchronously
    assign cfg.send     = (state == S_SEND);
    assign cfg.id       = DEVICE_ID;
    assign cfg.register = reg_q;
    assign cfg.value    = val_q;
    assign busy         = (state != S_DONE);
    assign done         = (state == S_DONE);

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Scoreboard bench: full-table DUT with short delay, plus an 8-entry DUT with no end marker.
`timescale 1ns/1ps
module tb_ov7670_config_seq;
    import ov7670_pkg::*;

    localparam int DC = 3;

    typedef struct {
        logic [7:0] r;
        logic [7:0] v;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, done_a, busy_b, done_b;
`ifdef OV7670_CFG_RESEND_EN
    logic resend = 1'b0;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_a, n_b;
    int acc_a = 0, acc_b = 0;
    int rel_cyc = 0, ref_a = 0;
    int wcnt = 0, wlim = 0;
    bit long_en = 1'b0;
    bit prev_a = 1'b0, fresh_a = 1'b1, unst_a = 1'b0;
    logic [7:0] sr, sv;
    exp_t exp_a[$], exp_b[$];
    exp_t ea, eb;
    logic [15:0] tbl [22];

    ov7670_config_seq_if a_if ();
    ov7670_config_seq_if b_if ();

    ov7670_config_seq #(
        .CLK_FREQ_HZ(1000), .DELAY_MS(DC), .ROM_AW(8)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef OV7670_CFG_RESEND_EN
        .resend(resend),
`endif
        .cfg   (a_if.master),
        .busy  (busy_a),
        .done  (done_a)
    );

    ov7670_config_seq #(
        .CLK_FREQ_HZ(1000), .DELAY_MS(DC), .ROM_AW(3)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef OV7670_CFG_RESEND_EN
        .resend(resend),
`endif
        .cfg   (b_if.master),
        .busy  (busy_b),
        .done  (done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: expand the table into expected writes and their start gaps
    function automatic int build(int depth, bit to_b);
        int gap = 2;
        int n = 0;
        exp_t e;
        if (to_b) exp_b.delete();
        else exp_a.delete();
        for (int i = 0; i < depth && i < 22; i++) begin
            if (tbl[i] == CFG_END) break;
            if (tbl[i] == CFG_DELAY) begin
                gap += DC + 2;
                continue;
            end
            e.r = tbl[i][15:8];
            e.v = tbl[i][7:0];
            e.gap = gap;
            if (to_b) exp_b.push_back(e);
            else exp_a.push_back(e);
            gap = 3;
            n++;
        end
        return n;
    endfunction

    // Sender A: random latency, one 300-cycle hold, spurious taken while idle
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            a_if.taken = 1'b0;
            wcnt = 0;
        end else if (a_if.send) begin
            a_if.taken = (wcnt >= wlim);
            wcnt = a_if.taken ? 0 : wcnt + 1;
        end else begin
            wlim = (long_en && acc_a == 3) ? 300 : $urandom_range(0, 6);
            wcnt = 0;
            a_if.taken = ($urandom_range(0, 3) == 0);
        end
    end

    // Sender B: acknowledges on the first cycle of each request
    always @(posedge clk) begin
        #2;
        b_if.taken = rst_n && b_if.send;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_a = 1'b0;
            fresh_a = 1'b1;
            acc_a = 0;
        end else begin
            if (a_if.send && !prev_a) begin
                if (exp_a.size() == 0) chk("extra_send_a", 1, 0);
                else chk("gap_a", cyc - (fresh_a ? rel_cyc : ref_a), exp_a[0].gap);
                sr = a_if.register;
                sv = a_if.value;
                unst_a = 1'b0;
            end
            if (a_if.send && (a_if.register != sr || a_if.value != sv))
                unst_a = 1'b1;
            if (a_if.send && a_if.taken) begin
                if (exp_a.size() == 0) begin
                    chk("extra_take_a", 1, 0);
                end else begin
                    ea = exp_a.pop_front();
                    chk("reg_a", a_if.register, ea.r);
                    chk("val_a", a_if.value, ea.v);
                    chk("id_a", a_if.id, 8'h42);
                    chk("stable_a", unst_a, 0);
                end
                acc_a++;
                ref_a = cyc;
                fresh_a = 1'b0;
            end
            prev_a = a_if.send;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_b = 0;
        end else if (b_if.send && b_if.taken) begin
            if (exp_b.size() == 0) begin
                chk("extra_take_b", 1, 0);
            end else begin
                eb = exp_b.pop_front();
                chk("reg_b", b_if.register, eb.r);
                chk("val_b", b_if.value, eb.v);
            end
            acc_b++;
        end
    end

    task automatic wait_done(int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done_a && done_b) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_end(string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_done_a"}, done_a, 1);
        chk({tag, "_busy_a"}, busy_a, 0);
        chk({tag, "_send_a"}, a_if.send, 0);
        chk({tag, "_count_a"}, acc_a, n_a);
        chk({tag, "_left_a"}, exp_a.size(), 0);
        chk({tag, "_done_b"}, done_b, 1);
        chk({tag, "_busy_b"}, busy_b, 0);
        chk({tag, "_count_b"}, acc_b, n_b);
        chk({tag, "_left_b"}, exp_b.size(), 0);
    endtask

    initial begin
        bit ok;
        tbl = '{16'h1280, 16'hFFF0, 16'h1204, 16'h40D0, 16'h8C00, 16'h1180,
                16'h3A04, 16'h3DC0, 16'h1713, 16'h1801, 16'h32B6, 16'h1902,
                16'h1A7A, 16'h030A, 16'h0C00, 16'h3E00, 16'h703A, 16'h7135,
                16'h7211, 16'h73F0, 16'hA202, 16'hFFFF};
        a_if.taken = 1'b0;
        b_if.taken = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_send", a_if.send, 0);
        chk("rst_busy", busy_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_reg", a_if.register, 0);
        chk("rst_val", a_if.value, 0);
        n_a = build(256, 1'b0);
        n_b = build(8, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rel_cyc = cyc;

        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (acc_a >= 5 && a_if.send) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reach", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_send", a_if.send, 0);
        chk("mid_rst_busy", busy_a, 1);
        chk("mid_rst_reg", a_if.register, 0);
        n_a = build(256, 1'b0);
        n_b = build(8, 1'b1);
        long_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        rel_cyc = cyc;

        wait_done(5000, ok);
        chk("done_reach", ok, 1);
        check_end("end");

`ifdef OV7670_CFG_RESEND_EN
        long_en = 1'b0;
        n_a = build(256, 1'b0);
        n_b = build(8, 1'b1);
        acc_a = 0;
        acc_b = 0;
        fresh_a = 1'b1;
        #1 resend = 1'b1;
        rel_cyc = cyc;
        @(negedge clk);
        #1 resend = 1'b0;
        chk("resend_done", done_a, 0);
        chk("resend_busy", busy_a, 1);
        wait_done(5000, ok);
        chk("resend_reach", ok, 1);
        check_end("replay");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
